// File: rtl/timer_counter_if.sv
// Bus bundle between the system bridge and one timer_counter instance.
//   Sel    : chip-select for this instance
//   Addr   : byte address; the timer decodes only Addr[3:2]
//   WE     : write strobe
//   ByteEn : byte lanes to write
//   Din    : write data from the CPU
//   Dout   : combinational read data back to the CPU
//   IRQ    : interrupt request toward HWInt
// The master modport is the bridge/CPU side; the slave modport is the timer.
interface timer_counter_if;
  logic        Sel;
  logic [31:0] Addr;
  logic        WE;
  logic [3:0]  ByteEn;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (
    output Sel,
    output Addr,
    output WE,
    output ByteEn,
    output Din,
    input  Dout,
    input  IRQ
  );

  modport slave (
    input  Sel,
    input  Addr,
    input  WE,
    input  ByteEn,
    input  Din,
    output Dout,
    output IRQ
  );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with one-shot and auto-reload modes.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : timer_counter_if.slave (Sel, Addr, WE, ByteEn, Din in; Dout, IRQ out)
// Register map (Addr[3:2]): 0 CTRL {IM, Mode[1:0], Enable}, 1 PRESET, 2 COUNT (read-only),
// 3 reserved (reads 0). IRQ = IM & irq_flag.
module timer_counter #(
  parameter logic [31:0] RESET_PRESET = 32'd0
) (
  input logic            clk,
  input logic            reset,
  timer_counter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegPreset = 2'd1;
  localparam logic [1:0] RegCount  = 2'd2;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic [1:0]  reg_idx;
  logic        wr_en, wr_ctrl, wr_preset;
  logic        enable, auto_reload, irq_mask;
  logic        fsm_load, fsm_dec, fsm_expire, fsm_clr_en, fsm_clr_irq;
  logic        unused_addr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  assign reg_idx     = bus.Addr[3:2];
  assign unused_addr = ^{bus.Addr[31:4], bus.Addr[1:0]};
  assign wr_en       = bus.Sel & bus.WE & (bus.ByteEn != 4'd0);
  assign wr_ctrl     = wr_en & (reg_idx == RegCtrl);
  assign wr_preset   = wr_en & (reg_idx == RegPreset);

  assign enable      = ctrl_q[0];
  // Mode 1x behaves like one-shot, so only 01 selects auto-reload.
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign irq_mask    = ctrl_q[3];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (enable) state_d = StLoad;
      StLoad: state_d = StCnt;
      StCnt: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (count_q <= 32'd1) begin
          state_d = StInt;
        end
      end
      StInt: state_d = auto_reload ? StLoad : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: control strobes for the datapath
  always_comb begin
    fsm_load    = 1'b0;
    fsm_dec     = 1'b0;
    fsm_expire  = 1'b0;
    fsm_clr_en  = 1'b0;
    fsm_clr_irq = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: fsm_load = 1'b1;
      StCnt: begin
        if (enable) begin
          fsm_dec    = (count_q > 32'd1);
          fsm_expire = (count_q <= 32'd1);
        end
      end
      StInt: begin
        fsm_clr_en  = ~auto_reload;
        // Leaving INT in auto-reload makes irq_flag a one-cycle pulse.
        fsm_clr_irq = auto_reload;
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    if (fsm_clr_en) begin
      ctrl_d[0] = 1'b0;
    end
    // A CTRL write overrides the FSM's one-shot Enable clear.
    if (wr_ctrl && bus.ByteEn[0]) begin
      ctrl_d = bus.Din[3:0];
    end

    if (wr_preset) begin
      preset_d = merge_bytes(preset_q, bus.Din, bus.ByteEn);
    end

    if (fsm_load) begin
      count_d = preset_q;
    end else if (fsm_dec) begin
      count_d = count_q - 32'd1;
    end else if (fsm_expire) begin
      count_d = 32'd0;
    end

    if (fsm_clr_irq || wr_ctrl || wr_preset) begin
      irq_flag_d = 1'b0;
    end
    // Setting the flag takes priority over any clear in the same cycle.
    if (fsm_expire) begin
      irq_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= 4'd0;
      preset_q   <= RESET_PRESET;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Read mux
  always_comb begin
    bus.Dout = 32'd0;
    if (bus.Sel) begin
      unique case (reg_idx)
        RegCtrl:   bus.Dout = {28'd0, ctrl_q};
        RegPreset: bus.Dout = preset_q;
        RegCount:  bus.Dout = count_q;
        default:   bus.Dout = 32'd0;
      endcase
    end
  end

  assign bus.IRQ = irq_mask & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

  typedef struct {
    string       name;
    logic [31:0] dout;
    logic        irq;
  } exp_t;

  logic clk;
  logic reset;
  logic rd_req;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  timer_counter_if bus_if ();

  timer_counter #(
    .RESET_PRESET(32'd5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops one expectation per sampled cycle, away from the active edge.
  always @(negedge clk) begin
    if (rd_req) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: sample with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (bus_if.Dout !== e.dout) begin
          failures++;
          $display("FAIL %s dout: got %08h want %08h", e.name, bus_if.Dout, e.dout);
        end
        checks++;
        if (bus_if.IRQ !== e.irq) begin
          failures++;
          $display("FAIL %s irq: got %b want %b", e.name, bus_if.IRQ, e.irq);
        end
      end
    end
  end

  task automatic bus_write(input logic [1:0] idx, input logic [31:0] data,
                           input logic [3:0] be);
    @(posedge clk);
    #1;
    bus_if.Sel    = 1'b1;
    bus_if.WE     = 1'b1;
    bus_if.Addr   = {28'd0, idx, 2'b00};
    bus_if.ByteEn = be;
    bus_if.Din    = data;
    rd_req        = 1'b0;
  endtask

  task automatic sample(input string name, input logic sel, input logic [1:0] idx,
                        input logic [31:0] exp_dout, input logic exp_irq);
    exp_t e;
    @(posedge clk);
    #1;
    bus_if.Sel    = sel;
    bus_if.WE     = 1'b0;
    bus_if.ByteEn = 4'd0;
    bus_if.Addr   = {28'd0, idx, 2'b00};
    e.name = name;
    e.dout = exp_dout;
    e.irq  = exp_irq;
    exp_q.push_back(e);
    rd_req = 1'b1;
  endtask

  task automatic nop(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus_if.Sel    = 1'b0;
      bus_if.WE     = 1'b0;
      bus_if.ByteEn = 4'd0;
      rd_req        = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    rd_req        = 1'b0;
    reset         = 1'b0;
    bus_if.Sel    = 1'b0;
    bus_if.WE     = 1'b0;
    bus_if.Addr   = 32'd0;
    bus_if.ByteEn = 4'd0;
    bus_if.Din    = 32'd0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;

    // Reset values
    sample("rst_ctrl", 1'b1, 2'd0, 32'd0, 1'b0);
    sample("rst_preset", 1'b1, 2'd1, 32'd5, 1'b0);
    sample("rst_count", 1'b1, 2'd2, 32'd0, 1'b0);
    sample("rst_unsel", 1'b0, 2'd1, 32'd0, 1'b0);
    sample("rst_reserved", 1'b1, 2'd3, 32'd0, 1'b0);

    // One-shot, PRESET=3, IM=1
    bus_write(2'd1, 32'd3, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    sample("os_e0", 1'b1, 2'd2, 32'd0, 1'b0);
    sample("os_e1", 1'b1, 2'd2, 32'd0, 1'b0);
    sample("os_e2", 1'b1, 2'd2, 32'd3, 1'b0);
    sample("os_e3", 1'b1, 2'd2, 32'd2, 1'b0);
    sample("os_e4", 1'b1, 2'd2, 32'd1, 1'b0);
    sample("os_e5", 1'b1, 2'd2, 32'd0, 1'b1);
    sample("os_ctrl_en_clr", 1'b1, 2'd0, 32'h8, 1'b1);
    sample("os_irq_hold1", 1'b1, 2'd0, 32'h8, 1'b1);
    sample("os_irq_hold2", 1'b0, 2'd0, 32'd0, 1'b1);
    bus_write(2'd0, 32'd0, 4'hF);
    sample("os_irq_clr", 1'b1, 2'd0, 32'd0, 1'b0);

    // Auto-reload, PRESET=2: pulse every 4 cycles, first in the cycle after E4
    bus_write(2'd1, 32'd2, 4'hF);
    bus_write(2'd0, 32'hB, 4'hF);
    for (int j = 0; j <= 20; j++) begin
      sample($sformatf("ar_e%0d", j), 1'b1, 2'd0, 32'hB, (j >= 4) && ((j - 4) % 4 == 0));
    end
    // Disable lands right after a reload: COUNT stops at PRESET=2
    bus_write(2'd0, 32'd0, 4'hF);
    nop(2);
    sample("ar_off_count", 1'b1, 2'd2, 32'd2, 1'b0);

    // Byte-lane merge and read-only COUNT
    bus_write(2'd1, 32'h11223344, 4'hF);
    bus_write(2'd1, 32'hAABBCCDD, 4'b0101);
    sample("merge_preset", 1'b1, 2'd1, 32'h11BB33DD, 1'b0);
    bus_write(2'd2, 32'hFFFFFFFF, 4'hF);
    sample("count_ro", 1'b1, 2'd2, 32'd2, 1'b0);

    // Mid-count PRESET write then disable; one-shot, IM=0
    bus_write(2'd1, 32'd10, 4'hF);
    bus_write(2'd0, 32'h1, 4'hF);
    for (int j = 0; j <= 5; j++) begin
      sample($sformatf("mc_e%0d", j), 1'b1, 2'd2, (j < 2) ? 32'd2 : 32'(12 - j), 1'b0);
    end
    bus_write(2'd1, 32'd20, 4'hF);
    bus_write(2'd0, 32'd0, 4'hF);
    sample("mc_freeze0", 1'b1, 2'd2, 32'd4, 1'b0);
    sample("mc_freeze1", 1'b1, 2'd2, 32'd4, 1'b0);
    sample("mc_freeze2", 1'b1, 2'd2, 32'd4, 1'b0);
    sample("mc_preset20", 1'b1, 2'd1, 32'd20, 1'b0);

    // Re-enable reloads through LOAD
    bus_write(2'd0, 32'h9, 4'hF);
    for (int j = 0; j <= 17; j++) begin
      sample($sformatf("re_e%0d", j), 1'b1, 2'd2, (j < 2) ? 32'd4 : 32'(22 - j), 1'b0);
    end

    // Async reset while COUNT=4, away from the clock edge
    begin
      exp_t e;
      @(posedge clk);
      #2;
      reset         = 1'b0;
      bus_if.Sel    = 1'b1;
      bus_if.WE     = 1'b0;
      bus_if.ByteEn = 4'd0;
      bus_if.Addr   = {28'd0, 2'd2, 2'b00};
      e.name = "arst_count";
      e.dout = 32'd0;
      e.irq  = 1'b0;
      exp_q.push_back(e);
      rd_req = 1'b1;
      @(posedge clk);
      #3;
      rd_req = 1'b0;
      reset  = 1'b1;
    end
    sample("arst_ctrl", 1'b1, 2'd0, 32'd0, 1'b0);
    sample("arst_preset", 1'b1, 2'd1, 32'd5, 1'b0);
    for (int j = 0; j < 6; j++) begin
      sample($sformatf("arst_quiet%0d", j), 1'b1, 2'd2, 32'd0, 1'b0);
    end

    nop(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counting timer that sits on the system bridge directly downstream of the CPU's data port. It consumes the CPU's store address, write data and byte enables, returns read data on the CPUIn path, and drives one bit of the CPU's HWInt vector. Two instances, TC0 and TC1, are placed in the bridge address map. Each instance supports a one-shot mode and an auto-reload periodic mode.

## Interface
Parameters:
- RESET_PRESET, default 32'd0: value loaded into PRESET on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low. Low clears every register immediately.
- Sel  input  1  bridge chip-select for this instance.
- Addr  input  32  byte address (VAdd). Only Addr[3:2] is decoded: 0 selects CTRL, 1 selects PRESET, 2 selects COUNT, 3 is reserved.
- WE  input  1  write strobe. A write occurs when Sel & WE & (ByteEn != 0).
- ByteEn  input  4  byte lanes to write (CPUByteEn).
- Din  input  32  write data (CPUOut).
- Dout  output  32  combinational read data for the register selected by Addr[3:2]. It is 0 when Sel is low or Addr[3:2] is 3.
- IRQ  output  1  interrupt request to HWInt, equal to IM & irq_flag.

## Operation
- Registers:
  - CTRL[0] is Enable.
  - CTRL[2:1] is Mode: 00 is one-shot, 01 is auto-reload, 1x is treated as 00.
  - CTRL[3] is IM, the interrupt mask.
  - CTRL[31:4] reads as 0; writes to those bits are ignored.
  - PRESET is fully read/write.
  - COUNT is read-only; writes to it are ignored.
- Byte-lane merge: for each lane i with ByteEn[i]=1, the new byte is Din[8i+7:8i]. Lanes with ByteEn[i]=0 keep their old value.
- FSM states are IDLE, LOAD, CNT and INT.
  - IDLE: go to LOAD when Enable=1.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if Enable=0, go to IDLE with COUNT held. Otherwise, if COUNT > 1, decrement COUNT. Otherwise (COUNT is 1 or 0), set COUNT <= 0 and irq_flag <= 1, and go to INT.
  - INT, Mode 00: Enable <= 0 and go to IDLE. irq_flag stays set.
  - INT, Mode 01: go to LOAD. irq_flag <= 0 on leaving INT, so the flag is a one-cycle pulse.
- irq_flag clear rules:
  - Any write to CTRL or PRESET clears irq_flag.
  - If that write lands in the same cycle that the FSM would set irq_flag, the set wins.
- Simultaneous CTRL write and FSM Enable clear in INT: the CTRL write value wins.
- A PRESET write during CNT does not alter the running COUNT. It takes effect at the next LOAD.
- Re-enabling from IDLE after Enable was cleared mid-count always passes through LOAD, so counting restarts from PRESET.
- Reset (asynchronous, active-low) sets:
  - state = IDLE
  - CTRL = 0
  - PRESET = RESET_PRESET
  - COUNT = 0
  - irq_flag = 0
  - Hence IRQ = 0 and Dout = 0 when unselected.
- Reset asserted mid-count aborts immediately with no interrupt.

## Timing
- Dout has zero latency: it is combinational from Addr, Sel and the current register values.
- A write takes effect at the clock edge where the write condition is true; call this edge E0.
- Timeline after a write that sets Enable with PRESET = N:
  - E0: Enable = 1, state still IDLE.
  - E1: state = LOAD.
  - E2: COUNT = N, state = CNT.
  - E2+k: COUNT = N-k, for 1 ≤ k < N.
  - E2+N: COUNT = 0, irq_flag = 1, state = INT. For N = 0 this happens at E3.
- IRQ rises in the cycle after edge E2+N (E3 when N = 0) if IM = 1.
- One-shot (Mode 00): IRQ stays high until a CTRL or PRESET write.
- Auto-reload (Mode 01):
  - IRQ is high for exactly 1 cycle.
  - IRQ pulses repeat every N+2 cycles for N ≥ 1, and every 3 cycles for N = 0 or 1.
- IM only gates IRQ. irq_flag still sets while IM = 0, so setting IM later exposes a pending one-shot interrupt.

## Test plan
- Reset with RESET_PRESET=5, then hold reset high → IRQ=0, CTRL reads 0, PRESET reads 5, COUNT reads 0.
- Write PRESET=3 (ByteEn=4'hF), then CTRL=32'h9 (Enable, IM, one-shot) → COUNT reads 3, 2, 1, 0 at E2..E5. IRQ goes high after E5 and stays high. CTRL[0] reads 0. A write CTRL=0 drops IRQ the next cycle.
- PRESET=2, CTRL=32'hB (auto-reload) → IRQ is a one-cycle pulse every 4 cycles for 5 periods. CTRL[0] stays 1.
- Write Din=32'hAABBCCDD to PRESET with ByteEn=4'b0101 over an old value of 32'h11223344 → PRESET reads 32'h11BB33DD. A write to COUNT leaves COUNT unchanged.
- During CNT at COUNT=7, write PRESET=20 and then CTRL=0 → COUNT freezes at its value. Re-enabling reloads COUNT=20 via LOAD, and no IRQ fires while disabled.
- Assert reset low asynchronously mid-count at COUNT=4 (not on a clock edge) → COUNT=0, state IDLE, IRQ=0 immediately. After release, no IRQ occurs until a new enable.
